// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock; done WIDTH+1 edges after accept (2 for divide-by-zero).
// start is only honoured while busy=0; requests during a division are dropped and operands are not re-sampled.
module seq_restoring_divider #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nxt;

  // The partial remainder never reaches the divisor after a step, so WIDTH bits
  // hold it; the extra bit only exists in the shifted trial value.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic             accept;
  logic             d_zero;

  assign accept = (state == IDLE) && start;
  assign d_zero = (d == '0);
  assign busy   = (state != IDLE);
  assign r_sh   = {r, q[WIDTH-1]};
  assign t      = r_sh - {1'b0, d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The zero-divisor decision is taken on the latched divisor in the first
  // busy cycle, which skips the iterations and goes straight to FIN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (d_zero || cnt == CNT_W'(1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r   <= '0;
      q   <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (accept) begin
      r   <= '0;
      q   <= dividend;
      d   <= divisor;
      cnt <= CNT_W'(WIDTH);
    end else if (state == RUN && !d_zero) begin
      r   <= t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
      q   <= {q[WIDTH-2:0], ~t[WIDTH]};
      cnt <= cnt - CNT_W'(1);
    end
  end

  // On the zero-divisor path q was never shifted, so it still holds the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (state == FIN) begin
        if (d_zero) begin
          quotient    <= '1;
          remainder   <= q;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= q;
          remainder   <= r;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed scenarios plus a random sweep against an arithmetic reference model.
module tb_seq_restoring_divider;
  localparam int WIDTH = 8;
  localparam int BUDGET = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division; a zero divisor yields all ones and the dividend.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 2;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = WIDTH + 1;
    end
  endfunction

  // Issue one request and wait for done; returns at #1 after the done-raising edge.
  task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat, output int busy_cnt,
                         output logic [WIDTH-1:0] qo, output logic [WIDTH-1:0] ro,
                         output logic zo);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < BUDGET) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    qo = quotient; ro = remainder; zo = div_by_zero;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [WIDTH-1:0] tbl_a [4] = '{8'd100, 8'd255, 8'd5, 8'd255};
    logic [WIDTH-1:0] tbl_b [4] = '{8'd7, 8'd1, 8'd9, 8'd255};
    logic [WIDTH-1:0] tbl_q [4] = '{8'd14, 8'd255, 8'd0, 8'd1};
    logic [WIDTH-1:0] tbl_r [4] = '{8'd2, 8'd0, 8'd5, 8'd0};
    int lat, bc;
    logic [WIDTH-1:0] qo, ro;
    logic zo;
    for (int i = 0; i < 4; i++) begin
      run_div(tbl_a[i], tbl_b[i], lat, bc, qo, ro, zo);
      checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency %0d/%0d: got %0d expected 9", tbl_a[i], tbl_b[i], lat); end
      checks++; if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles %0d/%0d: got %0d expected 9", tbl_a[i], tbl_b[i], bc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
      checks++; if (qo !== tbl_q[i]) begin errors++; $display("FAIL basic_quotient %0d/%0d: got %0d expected %0d", tbl_a[i], tbl_b[i], qo, tbl_q[i]); end
      checks++; if (ro !== tbl_r[i]) begin errors++; $display("FAIL basic_remainder %0d/%0d: got %0d expected %0d", tbl_a[i], tbl_b[i], ro, tbl_r[i]); end
      checks++; if (zo !== 1'b0) begin errors++; $display("FAIL basic_dbz %0d/%0d: got %b expected 0", tbl_a[i], tbl_b[i], zo); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    logic [WIDTH-1:0] qo, ro;
    logic zo;
    run_div(8'd77, 8'd0, lat, bc, qo, ro, zo);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dbz_latency: got %0d expected 2", lat); end
    checks++; if (qo !== 8'd255) begin errors++; $display("FAIL dbz_quotient: got %0d expected 255", qo); end
    checks++; if (ro !== 8'd77) begin errors++; $display("FAIL dbz_remainder: got %0d expected 77", ro); end
    checks++; if (zo !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", zo); end
    run_div(8'd10, 8'd3, lat, bc, qo, ro, zo);
    checks++; if (lat !== 9) begin errors++; $display("FAIL after_dbz_latency: got %0d expected 9", lat); end
    checks++; if (qo !== 8'd3) begin errors++; $display("FAIL after_dbz_quotient: got %0d expected 3", qo); end
    checks++; if (ro !== 8'd1) begin errors++; $display("FAIL after_dbz_remainder: got %0d expected 1", ro); end
    checks++; if (zo !== 1'b0) begin errors++; $display("FAIL after_dbz_flag: got %b expected 0", zo); end
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    logic [WIDTH-1:0] qo = '0, ro = '0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd13;
    @(posedge clk); #1;
    dividend = 8'd9; divisor = 8'd2;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dividend = 8'($urandom); divisor = 8'($urandom);
    end
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done) begin dones++; qo = quotient; ro = remainder; end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    checks++; if (qo !== 8'd15) begin errors++; $display("FAIL ignore_quotient: got %0d expected 15", qo); end
    checks++; if (ro !== 8'd5) begin errors++; $display("FAIL ignore_remainder: got %0d expected 5", ro); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [WIDTH-1:0] qo, ro;
    logic zo;
    run_div(8'd20, 8'd3, lat, bc, qo, ro, zo);
    start = 1'b1; dividend = 8'd50; divisor = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accepted: got busy=%b expected 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 0", done); end
    lat = 0;
    while (!done && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency: got %0d expected 9", lat); end
    checks++; if (quotient !== 8'd8) begin errors++; $display("FAIL b2b_quotient: got %0d expected 8", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL b2b_remainder: got %0d expected 2", remainder); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, dones = 0;
    logic [WIDTH-1:0] qo, ro;
    logic zo;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL midrst_quotient: got %0d expected 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL midrst_remainder: got %0d expected 0", remainder); end
    checks++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_flags: got done=%b dbz=%b expected 0 0", done, div_by_zero); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d dones expected 0", dones); end
    run_div(8'd100, 8'd7, lat, bc, qo, ro, zo);
    checks++; if (lat !== 9 || qo !== 8'd14 || ro !== 8'd2) begin errors++; $display("FAIL midrst_fresh: got lat=%0d q=%0d r=%0d expected 9 14 2", lat, qo, ro); end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] a, b, qo, ro, eq, er;
    logic zo, ez;
    int lat, bc, elat, sel;
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      b = '0;
      else if (sel == 1) b = 8'($urandom_range(255, int'(a)));
      else if (sel == 2) b = 8'd1;
      else               b = 8'($urandom);
      model(a, b, eq, er, ez, elat);
      run_div(a, b, lat, bc, qo, ro, zo);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency %0d/%0d: got %0d expected %0d", a, b, lat, elat); end
      checks++; if (qo !== eq) begin errors++; $display("FAIL rand_quotient %0d/%0d: got %0d expected %0d", a, b, qo, eq); end
      checks++; if (ro !== er) begin errors++; $display("FAIL rand_remainder %0d/%0d: got %0d expected %0d", a, b, ro, er); end
      checks++; if (zo !== ez) begin errors++; $display("FAIL rand_dbz %0d/%0d: got %b expected %b", a, b, zo, ez); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
